// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J fields of an RV32 instruction word.
// Two-stage valid/ready pipeline with range/alignment check and saturating statistics.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [31:0]      base_i,
    input  logic [31:0]      imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instruction_o,
    output logic             err_o,
    output logic [CNT_W-1:0] enc_count_o,
    output logic [CNT_W-1:0] err_count_o
);

    typedef enum logic [1:0] {FMT_I, FMT_S, FMT_B, FMT_J} fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [31:0] base;
        logic [31:0] imm;
    } req_t;

    req_t        s1_req;
    logic        s1_vld, s2_vld;
    logic [31:0] s2_inst;
    logic        s2_err;

    fmt_e        s1_fmt;
    logic [31:0] s1_word;
    logic        s1_err;
    logic        s2_load, out_hs;

    assign s2_load     = !s2_vld || out_ready_i;
    assign in_ready_o  = !s1_vld || s2_load;
    assign out_hs      = s2_vld && out_ready_i;
    assign out_valid_o = s2_vld;
    assign instruction_o = s2_inst;
    assign err_o       = s2_err;

    always_comb begin
        case (s1_req.opcode)
            7'b0100011: s1_fmt = FMT_S;
            7'b1100011: s1_fmt = FMT_B;
            7'b1101111: s1_fmt = FMT_J;
            default:    s1_fmt = FMT_I;
        endcase
    end

    // Out-of-range immediates are still packed (truncated); err flags them.
    always_comb begin
        logic [31:0] imm;
        imm         = s1_req.imm;
        s1_word     = s1_req.base;
        s1_word[6:0] = s1_req.opcode;
        s1_err      = 1'b0;
        case (s1_fmt)
            FMT_S: begin
                s1_word[31:25] = imm[11:5];
                s1_word[11:7]  = imm[4:0];
                s1_err = imm != {{20{imm[11]}}, imm[11:0]};
            end
            FMT_B: begin
                s1_word[31]    = imm[12];
                s1_word[30:25] = imm[10:5];
                s1_word[11:8]  = imm[4:1];
                s1_word[7]     = imm[11];
                s1_err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            end
            FMT_J: begin
                s1_word[31]    = imm[20];
                s1_word[30:21] = imm[10:1];
                s1_word[20]    = imm[11];
                s1_word[19:12] = imm[19:12];
                s1_err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            end
            default: begin
                s1_word[31:20] = imm[11:0];
                s1_err = imm != {{20{imm[11]}}, imm[11:0]};
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld <= 1'b0;
            s1_req <= '0;
        end else if (in_ready_o) begin
            s1_vld <= in_valid_i;
            if (in_valid_i) s1_req <= '{opcode: opcode_i, base: base_i, imm: imm_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_vld  <= 1'b0;
            s2_inst <= '0;
            s2_err  <= 1'b0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_inst <= s1_word;
                s2_err  <= s1_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enc_count_o <= '0;
            err_count_o <= '0;
        end else if (out_hs) begin
            if (enc_count_o != '1)          enc_count_o <= enc_count_o + 1'b1;
            if (s2_err && err_count_o != '1) err_count_o <= err_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder; a second CNT_W=2 instance shares the stimulus for saturation.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [6:0]  opcode;
    logic [31:0] base, imm, inst;
    logic [15:0] enc_cnt, err_cnt;
    logic        s_in_ready, s_out_valid, s_err;
    logic [31:0] s_inst;
    logic [1:0]  s_enc_cnt, s_err_cnt;

    int n_vec = 0, n_err = 0;
    int hs = 0, errs = 0;
    bit rnd_rdy = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    imm_encoder u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .opcode_i(opcode), .base_i(base), .imm_i(imm), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .instruction_o(inst), .err_o(err),
        .enc_count_o(enc_cnt), .err_count_o(err_cnt)
    );

    imm_encoder #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .opcode_i(opcode), .base_i(base), .imm_i(imm), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .instruction_o(s_inst), .err_o(s_err),
        .enc_count_o(s_enc_cnt), .err_count_o(s_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic range test rather than sign-extension compare.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [31:0] b,
                                          input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        longint      v;
        v = longint'($signed(im));
        w = {b[31:7], op};
        if (op == 7'b0100011) begin
            w = (w & 32'h01FF_F07F) | ({25'd0, im[11:5]} << 25) | ({27'd0, im[4:0]} << 7);
            e = v < -2048 || v > 2047;
        end else if (op == 7'b1100011) begin
            w = (w & 32'h01FF_F07F) | ({31'd0, im[12]} << 31) | ({26'd0, im[10:5]} << 25)
                | ({28'd0, im[4:1]} << 8) | ({31'd0, im[11]} << 7);
            e = v < -4096 || v > 4095 || im[0];
        end else if (op == 7'b1101111) begin
            w = (w & 32'h0000_0FFF) | ({31'd0, im[20]} << 31) | ({22'd0, im[10:1]} << 21)
                | ({31'd0, im[11]} << 20) | ({24'd0, im[19:12]} << 12);
            e = v < -(64'sd1 <<< 20) || v > (64'sd1 <<< 20) - 1 || im[0];
        end else begin
            w = (w & 32'h000F_FFFF) | ({20'd0, im[11:0]} << 20);
            e = v < -2048 || v > 2047;
        end
        return {e, w};
    endfunction

    task automatic send(input logic [6:0] op, input logic [31:0] b, input logic [31:0] im,
                        input logic [32:0] exp);
        bit ok = 0;
        in_valid = 1'b1; opcode = op; base = b; imm = im;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(exp);
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_m(input logic [6:0] op, input logic [31:0] b, input logic [31:0] im);
        send(op, b, im, model(op, b, im));
    endtask

    task automatic drain;
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        q.delete();
        hs = 0; errs = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inst", {err, inst}, 0);
        chk("rst_cnt", {enc_cnt, err_cnt}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pop/compare on each output handshake, check counters and stall stability.
    initial begin
        bit          held = 0;
        logic [32:0] held_w = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held && out_valid) chk("stall_stable", {err, inst}, held_w);
                held = out_valid && !out_ready;
                held_w = {err, inst};
                if (out_valid && out_ready) begin
                    chk("enc_cnt", enc_cnt, hs);
                    chk("err_cnt", err_cnt, errs);
                    chk("sat_cnt", {s_enc_cnt, s_err_cnt},
                        {2'(hs > 3 ? 3 : hs), 2'(errs > 3 ? 3 : errs)});
                    if (q.size() == 0) chk("spurious_out", 1, 0);
                    else chk("word", {err, inst}, q.pop_front());
                    hs++;
                    if (err) errs++;
                end
            end else held = 0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  ops [6];
        logic [6:0]  bop [3];
        logic [31:0] bim [3];
        int          k;
        ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h13, 7'h67};
        in_valid = 0; out_ready = 1; opcode = 0; base = 0; imm = 0; rst_n = 1;
        @(posedge clk); #1;
        do_reset();

        // Directed: I, with explicit 2-cycle latency check.
        send(7'b0000011, 32'h0000_2083, 32'hFFFF_FFFC, {1'b0, 32'hFFC0_2083});
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 1);
        @(posedge clk); #1;
        send(7'b0000011, 32'h0000_2083, 32'h0000_0800, {1'b1, 32'h8000_2083});
        send(7'b0100011, 32'h0051_2000, 32'd36,         {1'b0, 32'h0251_2223});
        send(7'b1100011, 32'h0,         32'hFFFF_FFF8, {1'b0, 32'hFE00_0CE3});
        send_m(7'b1100011, 32'h0,       32'd3);
        send(7'b1101111, 32'h0000_0080, 32'h0000_0800, {1'b0, 32'h0010_00EF});
        send_m(7'b1101111, 32'h0000_0080, 32'h0010_0000);
        drain();
        chk("err_cnt_dir", err_cnt, 3);

        // Backpressure: 3 offered while stalled, only 2 fit.
        do_reset();
        bop = '{7'h13, 7'h23, 7'h6F};
        bim = '{32'd5, -32'sd12, 32'h0000_0FFE};
        out_ready = 0; k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; opcode = bop[k]; base = 32'h00A5_5000 + c; imm = bim[k];
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(opcode, base, imm));
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("bp_accepted", k, 2);
        @(negedge clk); chk("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1;
        send_m(bop[2], 32'h00A5_5000, bim[2]);
        drain();
        chk("bp_enc_cnt", enc_cnt, 3);

        // Reset with 2 words in flight, then fresh request right after release.
        out_ready = 0;
        send_m(7'h03, 32'h1234_5000, 32'd7);
        send_m(7'h23, 32'h1234_5000, 32'd8);
        rst_n = 0; q.delete(); hs = 0; errs = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cnt", {enc_cnt, err_cnt}, 0);
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        send_m(7'h63, 32'h0, 32'h0000_0FFE);
        @(negedge clk); chk("rel_lat_c1", out_valid, 0);
        @(negedge clk); chk("rel_lat_c2", out_valid, 1);
        @(posedge clk); #1;

        // Random mix with random backpressure.
        rnd_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            case ($urandom_range(3))
                0: r = 32'($signed($urandom_range(8192)) - 4096);
                1: r = 32'($signed($urandom_range(1 << 22)) - (1 << 21));
                2: r = {$urandom_range(1) ? 12'hFFF : 12'h000, 20'($urandom)} & ~32'h1;
                default: r = $urandom;
            endcase
            send_m(ops[$urandom_range(5)], $urandom, r);
        end
        rnd_rdy = 0; out_ready = 1;
        drain();
        chk("final_enc_cnt", enc_cnt, hs);
        chk("sat_final", s_enc_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
